// File: rtl/mem_txn_sequencer.sv
// mem_txn_sequencer: four-phase write/read burst sequencer with read-back checking
module mem_txn_sequencer #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 4,
    parameter int NCH         = 2,
    parameter int NUM_TXN     = 16,
    parameter int ADDR_STEP   = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ERR_W       = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [1:0]            Mode,
    input  logic [ADDR_W-1:0]     BaseAddr,
    input  logic [DATA_W-1:0]     Seed,
    output logic [ADDR_W-1:0]     A,
    output logic [NCH-1:0]        RW,
    output logic [NCH*DATA_W-1:0] W,
    input  logic [NCH-1:0]        WdataAck,
    input  logic [NCH*DATA_W-1:0] R,
    output logic [NCH-1:0]        RDataAck,
    input  logic                  Ack,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Timeout,
    output logic [ERR_W-1:0]      ErrCount
);
    localparam int IW = $clog2(NUM_TXN + 1);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int MW = $clog2(NCH + 1);
    localparam int SW = ERR_W + MW;
    localparam logic [2*((NCH+1)/2)-1:0] wr_rep = {((NCH+1)/2){2'b01}};

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_REL, RD_REQ, RD_ACK, RD_REL, NEXT, DONE} state_t;

    state_t                state, state_n;
    logic [SYNC_STAGES-1:0] ack_sr;
    logic [NCH-1:0]        wack_sr [SYNC_STAGES];
    logic [NCH*DATA_W-1:0] r_sr [SYNC_STAGES];
    logic                  ack_s;
    logic [NCH-1:0]        wack_s;
    logic [NCH*DATA_W-1:0] r_s;
    logic [CW-1:0]         cnt;
    logic [1:0]            mode_q;
    logic [ADDR_W-1:0]     base_q, addr;
    logic [DATA_W-1:0]     seed_q, pat;
    logic [IW-1:0]         i;
    logic                  rd_pass, was_rd, tmo_q;
    logic [ERR_W-1:0]      err_count, err_sat;
    logic [MW-1:0]         mism;
    logic [SW-1:0]         sum;
    logic                  start_acc, adv, rewind, err_upd, to_hit, go, wait_st, last;

    assign ack_s  = ack_sr[SYNC_STAGES-1];
    assign wack_s = wack_sr[SYNC_STAGES-1];
    assign r_s    = r_sr[SYNC_STAGES-1];

    // Synchronise the macro's handshake and read data into the CLK domain
    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_sr <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                wack_sr[s] <= '0;
                r_sr[s]    <= '0;
            end
        end else begin
            ack_sr     <= {ack_sr[SYNC_STAGES-2:0], Ack};
            wack_sr[0] <= WdataAck;
            r_sr[0]    <= R;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                wack_sr[s] <= wack_sr[s-1];
                r_sr[s]    <= r_sr[s-1];
            end
        end
    end

    // Count read-back channel mismatches and form the saturated error total
    always_comb begin
        mism = '0;
        for (int c = 0; c < NCH; c++)
            mism = mism + MW'(r_s[c*DATA_W +: DATA_W] != pat + DATA_W'(c));
        sum     = SW'(err_count) + SW'(mism);
        err_sat = sum > SW'({ERR_W{1'b1}}) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    end

    // Next-state and sequencing decisions
    always_comb begin
        state_n   = state;
        start_acc = 1'b0;
        adv       = 1'b0;
        rewind    = 1'b0;
        wait_st   = state inside {WR_REQ, WR_REL, RD_REQ, RD_REL};
        go        = state == WR_REQ ? ack_s && &wack_s : state == RD_REQ ? ack_s : !ack_s;
        to_hit    = wait_st && !go && cnt == CW'(TIMEOUT_CYC);
        err_upd   = state == RD_REQ && ack_s;
        last      = i == IW'(NUM_TXN - 1);
        case (state)
            IDLE, DONE: begin
                start_acc = Start;
                state_n   = !Start ? state : Mode == 2'b01 ? RD_REQ : WR_REQ;
            end
            WR_REQ:  state_n = go ? WR_REL : to_hit ? DONE : state;
            WR_REL:  state_n = go ? NEXT : to_hit ? DONE : state;
            RD_REQ:  state_n = go ? RD_ACK : to_hit ? DONE : state;
            RD_ACK:  state_n = RD_REL;
            RD_REL:  state_n = go ? NEXT : to_hit ? DONE : state;
            NEXT: begin
                if (mode_q == 2'b11 && !was_rd) begin
                    state_n = RD_REQ;
                end else if (!last) begin
                    adv     = 1'b1;
                    state_n = (mode_q == 2'b01 || (mode_q == 2'b10 && rd_pass)) ? RD_REQ : WR_REQ;
                end else if (mode_q == 2'b10 && !rd_pass) begin
                    rewind  = 1'b1;
                    state_n = RD_REQ;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, per-state cycle counter and run context
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= '0;
            base_q    <= '0;
            seed_q    <= '0;
            addr      <= '0;
            pat       <= '0;
            i         <= '0;
            rd_pass   <= 1'b0;
            was_rd    <= 1'b0;
            err_count <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= state_n != state ? '0 : cnt + 1'b1;
            was_rd <= state == RD_REL ? 1'b1 : state == WR_REL ? 1'b0 : was_rd;
            if (err_upd)
                err_count <= err_sat;
            if (to_hit)
                tmo_q <= 1'b1;
            if (start_acc) begin
                mode_q    <= Mode;
                base_q    <= BaseAddr;
                seed_q    <= Seed;
                addr      <= BaseAddr;
                pat       <= Seed;
                i         <= '0;
                rd_pass   <= Mode == 2'b01;
                was_rd    <= 1'b0;
                err_count <= '0;
                tmo_q     <= 1'b0;
            end
            if (adv) begin
                i    <= i + 1'b1;
                addr <= addr + ADDR_W'(ADDR_STEP);
                pat  <= pat + 1'b1;
            end
            if (rewind) begin
                i       <= '0;
                addr    <= base_q;
                pat     <= seed_q;
                rd_pass <= 1'b1;
            end
        end
    end

    // Macro-side outputs decoded from the state; zero outside request phases
    always_comb begin
        W = '0;
        for (int c = 0; c < NCH; c++)
            W[c*DATA_W +: DATA_W] = state == WR_REQ ? pat + DATA_W'(c) : '0;
    end

    assign A        = state inside {WR_REQ, RD_REQ} ? addr : '0;
    assign RW       = state == WR_REQ ? wr_rep[NCH-1:0] : state == RD_REQ ? {NCH{1'b1}} : '0;
    assign RDataAck = state == RD_ACK ? {NCH{1'b1}} : '0;
    assign Busy     = !(state inside {IDLE, DONE});
    assign Done     = state == DONE;
    assign Timeout  = tmo_q;
    assign ErrCount = err_count;
endmodule
